// File: rtl/bru_pkg.sv
// rtl/bru_pkg.sv - MIPS control-transfer decode constants, branch type enum and BHT counter helpers
package bru_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;
    localparam logic [4:0] RT_BLTZAL  = 5'b10000;
    localparam logic [4:0] RT_BGEZAL  = 5'b10001;

    localparam logic [4:0] LINK_REG   = 5'd31;

    typedef enum logic [3:0] {
        BR_NONE, BR_BEQ, BR_BNE, BR_BLEZ, BR_BGTZ, BR_BLTZ, BR_BGEZ, BR_J, BR_JR
    } br_type_e;

    // Weakly not-taken: MSB clear, all lower bits set.
    function automatic int unsigned ctr_reset_val(input int unsigned bits);
        return (32'd1 << (bits - 1)) - 32'd1;
    endfunction

    function automatic logic is_cond(input br_type_e t);
        return t inside {BR_BEQ, BR_BNE, BR_BLEZ, BR_BGTZ, BR_BLTZ, BR_BGEZ};
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - ID/EX inputs and redirect/resolve/link outputs of the branch resolve unit
interface branch_resolve_unit_if #(parameter int XLEN = 32);
    logic            stall_in;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [5:0]      id_opcode;
    logic [4:0]      id_rt;
    logic [4:0]      id_rd;
    logic [5:0]      id_funct;
    logic [15:0]     id_imm16;
    logic [25:0]     id_instr_index;
    logic [XLEN-1:0] id_rs_val;
    logic [XLEN-1:0] ex_rs_val;
    logic [XLEN-1:0] ex_rt_val;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            flush_if;
    logic            ex_br_valid;
    logic            ex_taken;
    logic            mispredict;
    logic            link_valid;
    logic [4:0]      link_rd;
    logic [XLEN-1:0] link_data;

    modport master (
        output stall_in, id_valid, id_pc, id_opcode, id_rt, id_rd, id_funct, id_imm16,
               id_instr_index, id_rs_val, ex_rs_val, ex_rt_val,
        input  redirect, redirect_pc, flush_if, ex_br_valid, ex_taken, mispredict,
               link_valid, link_rd, link_data
    );

    modport slave (
        input  stall_in, id_valid, id_pc, id_opcode, id_rt, id_rd, id_funct, id_imm16,
               id_instr_index, id_rs_val, ex_rs_val, ex_rt_val,
        output redirect, redirect_pc, flush_if, ex_br_valid, ex_taken, mispredict,
               link_valid, link_rd, link_data
    );
endinterface

// File: rtl/bru_bht.sv
// rtl/bru_bht.sv - branch history table of saturating counters, one async read port and one write port
module bru_bht
    import bru_pkg::*;
#(
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [$clog2(ENTRIES)-1:0] rd_idx,
    output logic                       rd_taken,
    input  logic                       wr_en,
    input  logic [$clog2(ENTRIES)-1:0] wr_idx,
    input  logic                       wr_taken
);
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_reset_val(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    logic [CTR_BITS-1:0] ctr [ENTRIES];

    // Read sees the pre-update value when the same entry is written this cycle.
    assign rd_taken = ctr[rd_idx][CTR_BITS-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_INIT;
        end else if (wr_en) begin
            if (wr_taken) begin
                if (ctr[wr_idx] != CTR_MAX) ctr[wr_idx] <= ctr[wr_idx] + CTR_BITS'(1);
            end else begin
                if (ctr[wr_idx] != '0) ctr[wr_idx] <= ctr[wr_idx] - CTR_BITS'(1);
            end
        end
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - next-PC/branch control: ID decode+predict, EX resolve, link write-back
// Optional dynamic prediction with `BRU_BHT_EN; otherwise every conditional branch predicts not-taken.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CTR_BITS    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_resolve_unit_if.slave bus
);
    localparam int IDXW = $clog2(BHT_ENTRIES);

    typedef struct packed {
        logic            valid;
        br_type_e        btype;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        logic            pred;
        logic [IDXW-1:0] idx;
        logic            link;
        logic [4:0]      link_rd;
    } slot_t;

    br_type_e        id_type;
    logic            id_link;
    logic [4:0]      id_link_rd;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] id_target;
    logic [IDXW-1:0] id_idx;
    logic            id_pred;
    logic            id_redirect;
    slot_t           slot;
    slot_t           slot_d;
    logic            ex_cond;
    logic            ex_resolve;
    logic            ex_mis;
    logic            active;
    logic            link_en;
    logic            rs_neg;
    logic            rs_zero;

    assign id_idx    = bus.id_pc[IDXW+1:2];
    assign pc_plus4  = bus.id_pc + XLEN'(4);
    assign br_target = pc_plus4 + {{(XLEN-18){bus.id_imm16[15]}}, bus.id_imm16, 2'b00};

    always_comb begin
        id_type    = BR_NONE;
        id_link    = 1'b0;
        id_link_rd = LINK_REG;
        if (bus.id_valid) begin
            case (bus.id_opcode)
                OP_BEQ:  id_type = BR_BEQ;
                OP_BNE:  id_type = BR_BNE;
                OP_BLEZ: id_type = BR_BLEZ;
                OP_BGTZ: id_type = BR_BGTZ;
                OP_REGIMM: begin
                    case (bus.id_rt)
                        RT_BLTZ:   id_type = BR_BLTZ;
                        RT_BGEZ:   id_type = BR_BGEZ;
                        RT_BLTZAL: begin id_type = BR_BLTZ; id_link = 1'b1; end
                        RT_BGEZAL: begin id_type = BR_BGEZ; id_link = 1'b1; end
                        default:   id_type = BR_NONE;
                    endcase
                end
                OP_J:   id_type = BR_J;
                OP_JAL: begin id_type = BR_J; id_link = 1'b1; end
                OP_SPECIAL: begin
                    if (bus.id_funct == FN_JR) begin
                        id_type = BR_JR;
                    end else if (bus.id_funct == FN_JALR) begin
                        id_type    = BR_JR;
                        id_link    = 1'b1;
                        id_link_rd = bus.id_rd;
                    end
                end
                default: id_type = BR_NONE;
            endcase
        end
    end

    always_comb begin
        case (id_type)
            BR_J:    id_target = {pc_plus4[XLEN-1:28], bus.id_instr_index, 2'b00};
            BR_JR:   id_target = bus.id_rs_val;
            default: id_target = br_target;
        endcase
    end

`ifdef BRU_BHT_EN
    bru_bht #(.ENTRIES(BHT_ENTRIES), .CTR_BITS(CTR_BITS)) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (id_idx),
        .rd_taken (id_pred),
        .wr_en    (active && ex_resolve),
        .wr_idx   (slot.idx),
        .wr_taken (ex_cond)
    );
`else
    assign id_pred = 1'b0;
    logic unused_bht;
    assign unused_bht = ^{slot.idx, id_idx, {CTR_BITS{1'b0}}};
`endif

    assign id_redirect = (id_type == BR_J) || (id_type == BR_JR) || (is_cond(id_type) && id_pred);

    assign rs_neg  = bus.ex_rs_val[XLEN-1];
    assign rs_zero = (bus.ex_rs_val == '0);

    always_comb begin
        ex_cond = 1'b0;
        case (slot.btype)
            BR_BEQ:  ex_cond = (bus.ex_rs_val == bus.ex_rt_val);
            BR_BNE:  ex_cond = (bus.ex_rs_val != bus.ex_rt_val);
            BR_BLEZ: ex_cond = rs_neg || rs_zero;
            BR_BGTZ: ex_cond = !rs_neg && !rs_zero;
            BR_BLTZ: ex_cond = rs_neg;
            BR_BGEZ: ex_cond = !rs_neg;
            default: ex_cond = 1'b0;
        endcase
    end

    assign ex_resolve = slot.valid && is_cond(slot.btype);
    assign ex_mis     = ex_resolve && (ex_cond != slot.pred);
    assign active     = !reset && !bus.stall_in;
    assign link_en    = active && slot.valid && slot.link;

    always_comb begin
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.flush_if    = 1'b0;
        bus.ex_br_valid = active && ex_resolve;
        bus.ex_taken    = active && ex_resolve && ex_cond;
        bus.mispredict  = active && ex_mis;
        bus.link_valid  = link_en;
        bus.link_rd     = link_en ? slot.link_rd : 5'd0;
        bus.link_data   = link_en ? slot.pc + XLEN'(8) : '0;
        // EX recovery outranks any transfer decoded in the delay slot.
        if (active && ex_mis) begin
            bus.redirect    = 1'b1;
            bus.redirect_pc = ex_cond ? slot.target : slot.pc + XLEN'(8);
            bus.flush_if    = 1'b1;
        end else if (active && id_redirect) begin
            bus.redirect    = 1'b1;
            bus.redirect_pc = id_target;
        end
    end

    always_comb begin
        slot_d.valid   = (id_type != BR_NONE) && !ex_mis;
        slot_d.btype   = id_type;
        slot_d.pc      = bus.id_pc;
        slot_d.target  = id_target;
        slot_d.pred    = is_cond(id_type) && id_pred;
        slot_d.idx     = id_idx;
        slot_d.link    = id_link;
        slot_d.link_rd = id_link_rd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot <= '0;
        end else if (!bus.stall_in) begin
            slot <= slot_d;
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - table-driven scoreboard bench for branch_resolve_unit (honours BRU_BHT_EN)
module tb_branch_resolve_unit;

`ifdef BRU_BHT_EN
    localparam bit BHT = 1'b1;
`else
    localparam bit BHT = 1'b0;
`endif

    localparam logic [31:0] NOP = 32'h0;

    typedef struct {
        string       name;
        logic        rst, stall, valid;
        logic [31:0] pc, instr, idrs, exrs, exrt;
        logic        e_redir;
        logic [31:0] e_rpc;
        logic        e_flush, e_brv, e_taken, e_mis, e_lv;
        logic [4:0]  e_lrd;
        logic [31:0] e_ldata;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    branch_resolve_unit_if #(.XLEN(32)) bus ();

    branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(16), .CTR_BITS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
        return {op, 5'd3, rt, imm};
    endfunction
    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] idx);
        return {op, idx};
    endfunction
    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, 5'd4, 5'd0, rd, 5'd0, fn};
    endfunction

    function automatic vec_t I(input string n, input logic [31:0] pc, ins, idrs, exrs, exrt);
        vec_t v;
        v.name = n; v.rst = 1'b0; v.stall = 1'b0; v.valid = 1'b1;
        v.pc = pc; v.instr = ins; v.idrs = idrs; v.exrs = exrs; v.exrt = exrt;
        v.e_redir = 1'b0; v.e_rpc = '0; v.e_flush = 1'b0; v.e_brv = 1'b0;
        v.e_taken = 1'b0; v.e_mis = 1'b0; v.e_lv = 1'b0; v.e_lrd = '0; v.e_ldata = '0;
        return v;
    endfunction
    function automatic vec_t S(input vec_t v, input logic rst, input logic stall);
        v.rst = rst; v.stall = stall;
        return v;
    endfunction
    function automatic vec_t R(input vec_t v, input logic en, input logic [31:0] rpc, input logic flush);
        if (en) begin v.e_redir = 1'b1; v.e_rpc = rpc; v.e_flush = flush; end
        return v;
    endfunction
    function automatic vec_t X(input vec_t v, input logic taken, input logic mis);
        v.e_brv = 1'b1; v.e_taken = taken; v.e_mis = mis;
        return v;
    endfunction
    function automatic vec_t L(input vec_t v, input logic [4:0] rd, input logic [31:0] data);
        v.e_lv = 1'b1; v.e_lrd = rd; v.e_ldata = data;
        return v;
    endfunction

    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s actual=%0h required=%0h", n, f, act, req);
        end
    endtask

    task automatic check_out(input vec_t e);
        chk(e.name, "redirect",    32'(bus.redirect),    32'(e.e_redir));
        chk(e.name, "redirect_pc", bus.redirect_pc,      e.e_rpc);
        chk(e.name, "flush_if",    32'(bus.flush_if),    32'(e.e_flush));
        chk(e.name, "ex_br_valid", 32'(bus.ex_br_valid), 32'(e.e_brv));
        chk(e.name, "ex_taken",    32'(bus.ex_taken),    32'(e.e_taken));
        chk(e.name, "mispredict",  32'(bus.mispredict),  32'(e.e_mis));
        chk(e.name, "link_valid",  32'(bus.link_valid),  32'(e.e_lv));
        chk(e.name, "link_rd",     32'(bus.link_rd),     32'(e.e_lrd));
        chk(e.name, "link_data",   bus.link_data,        e.e_ldata);
    endtask

    task automatic drive(input vec_t v);
        reset              = v.rst;
        bus.stall_in       = v.stall;
        bus.id_valid       = v.valid;
        bus.id_pc          = v.pc;
        bus.id_opcode      = v.instr[31:26];
        bus.id_rt          = v.instr[20:16];
        bus.id_rd          = v.instr[15:11];
        bus.id_funct       = v.instr[5:0];
        bus.id_imm16       = v.instr[15:0];
        bus.id_instr_index = v.instr[25:0];
        bus.id_rs_val      = v.idrs;
        bus.ex_rs_val      = v.exrs;
        bus.ex_rt_val      = v.exrt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1);
    end

    initial begin
        vec_t e;
        logic [31:0] beq4, bne8, jr, jal40;
        beq4  = enc_i(6'b000100, 5'd0, 16'h0004);
        bne8  = enc_i(6'b000101, 5'd0, 16'h0008);
        jr    = enc_r(5'd0, 6'b001000);
        jal40 = enc_j(6'b000011, 26'h40);

        vecs.push_back(R(X(I("beq1_ex", 32'h104, NOP, 0, 5, 5), 1, 1), 1, 32'h114, 1));
        vecs.push_front(I("beq1_id", 32'h100, beq4, 0, 0, 0));
        vecs.push_back(R(I("beq2_id", 32'h100, beq4, 0, 0, 0), BHT, 32'h114, 0));
        vecs.push_back(R(X(I("beq2_ex", 0, NOP, 0, 5, 6), 0, BHT), BHT, 32'h108, 1));
        vecs.push_back(I("beq3_id", 32'h100, beq4, 0, 0, 0));
        vecs.push_back(R(X(I("beq3_ex", 0, NOP, 0, 7, 7), 1, 1), 1, 32'h114, 1));
        vecs.push_back(R(I("jr_id", 32'h500, jr, 32'h2000, 0, 0), 1, 32'h2000, 0));
        vecs.push_back(I("jr_ex", 0, NOP, 0, 0, 0));
        vecs.push_back(R(I("jal_id", 32'h400, jal40, 0, 0, 0), 1, 32'h100, 0));
        vecs.push_back(L(I("jal_ex", 0, NOP, 0, 0, 0), 5'd31, 32'h408));
        vecs.push_back(R(I("jalr_id", 32'h600, enc_r(5'd5, 6'b001001), 32'h3000, 0, 0), 1, 32'h3000, 0));
        vecs.push_back(L(I("jalr_ex", 0, NOP, 0, 0, 0), 5'd5, 32'h608));
        vecs.push_back(I("bgezal_id", 32'h308, enc_i(6'b000001, 5'b10001, 16'h0010), 0, 0, 0));
        vecs.push_back(L(X(I("bgezal_ex", 0, NOP, 0, 32'hFFFF_FFFF, 0), 0, 0), 5'd31, 32'h310));
        vecs.push_back(I("bne1_id", 32'h204, bne8, 0, 0, 0));
        vecs.push_back(R(X(I("bne1_ex", 0, NOP, 0, 1, 2), 1, 1), 1, 32'h228, 1));
        for (int k = 2; k <= 3; k++) begin
            vecs.push_back(R(I($sformatf("bne%0d_id", k), 32'h204, bne8, 0, 0, 0), BHT, 32'h228, 0));
            vecs.push_back(R(X(I($sformatf("bne%0d_ex", k), 0, NOP, 0, 1, 2), 1, !BHT), !BHT, 32'h228, 1));
        end
        vecs.push_back(R(I("bne4_id", 32'h204, bne8, 0, 0, 0), BHT, 32'h228, 0));
        vecs.push_back(R(X(I("bne4_ex", 0, NOP, 0, 3, 3), 0, BHT), BHT, 32'h20C, 1));
        vecs.push_back(R(I("bne5_id", 32'h204, bne8, 0, 0, 0), BHT, 32'h228, 0));
        vecs.push_back(R(X(I("bne5_ex", 0, NOP, 0, 1, 2), 1, !BHT), !BHT, 32'h228, 1));
        vecs.push_back(I("bgtz_id", 32'h710, enc_i(6'b000111, 5'd0, 16'h0002), 0, 0, 0));
        vecs.push_back(X(I("bgtz_ex", 0, NOP, 0, 32'h8000_0000, 0), 0, 0));
        vecs.push_back(I("blez_id", 32'h720, enc_i(6'b000110, 5'd0, 16'h0001), 0, 0, 0));
        vecs.push_back(R(X(I("blez_ex", 0, NOP, 0, 0, 0), 1, 1), 1, 32'h728, 1));
        vecs.push_back(I("bltz_id", 32'h70C, enc_i(6'b000001, 5'b00000, 16'hFFFF), 0, 0, 0));
        vecs.push_back(R(X(I("bltz_ex", 0, NOP, 0, 32'h8000_0000, 0), 1, 1), 1, 32'h70C, 1));
        // Mispredict held by stall, then released while ID holds a JALR that must be dropped.
        vecs.push_back(I("stl_id", 32'h0B4, enc_i(6'b000100, 5'd0, 16'h0001), 0, 0, 0));
        vecs.push_back(S(I("stl_a", 32'h0B8, jr, 32'h2000, 1, 1), 0, 1));
        vecs.push_back(S(I("stl_b", 32'h0B8, jr, 32'h2000, 1, 1), 0, 1));
        vecs.push_back(R(X(I("stl_rel", 32'h0B8, enc_r(5'd7, 6'b001001), 32'h2000, 1, 1), 1, 1), 1, 32'h0BC, 1));
        vecs.push_back(I("stl_after", 0, NOP, 0, 0, 0));
        vecs.push_back(R(I("rst_pre", 32'h400, jal40, 0, 0, 0), 1, 32'h100, 0));
        vecs.push_back(S(I("rst_mid", 32'h500, jr, 32'h2000, 0, 0), 1, 0));
        vecs.push_back(I("post_id", 32'h100, beq4, 0, 0, 0));
        vecs.push_back(X(I("post_ex", 0, NOP, 0, 5, 6), 0, 0));

        e = S(I("reset", 32'h500, jr, 32'h2000, 0, 0), 1, 0);
        drive(e);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_out(e);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty actual=0 required=1");
            end else begin
                e = exp_q.pop_front();
                check_out(e);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
